// File: rtl/freq_divider_prog.sv
`default_nettype none
// ============================================================================
// freq_divider_prog : programmable tick / square-wave divider with
//                     glitch-free divisor and mode update at period boundaries
// Revision 1.0
// ============================================================================
module freq_divider_prog #(
   parameter int unsigned WIDTH        = 16,
   parameter int unsigned DEFAULT_DIV  = 16,
   parameter bit          DEFAULT_MODE = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             sync_clr,
   input  logic             load,
   input  logic [WIDTH-1:0] div,
   input  logic             mode,
   output logic             tick,
   output logic             clk_out,
   output logic [WIDTH-1:0] count,
   output logic [WIDTH-1:0] cur_div,
   output logic             pend
);

   localparam logic [WIDTH-1:0] RST_DIV = WIDTH'(DEFAULT_DIV);

   logic             cur_mode;
   logic [WIDTH-1:0] pend_div;
   logic             pend_mode;
   logic             pend_idle;

   logic [WIDTH-1:0] ne;
   logic [WIDTH-1:0] last;
   logic [WIDTH:0]   half;
   logic [WIDTH-1:0] next_count;
   logic             wrap;
   logic             has_pend;
   logic             apply;
   logic [WIDTH-1:0] new_div;
   logic             new_mode;
   logic             square_next;

   // A divisor of 0 behaves as 1; half is one bit wider so N = 2**WIDTH-1 cannot overflow.
   assign ne          = (cur_div == '0) ? WIDTH'(1) : cur_div;
   assign last        = ne - WIDTH'(1);
   assign half        = ({1'b0, ne} + (WIDTH+1)'(1)) >> 1;
   assign wrap        = en && (count == last);
   assign next_count  = wrap ? '0 : count + WIDTH'(1);
   assign square_next = cur_mode && ({1'b0, next_count} < half);

   // A load on the same edge supersedes the stored pending value.
   assign has_pend = load | pend;
   assign new_div  = load ? div  : pend_div;
   assign new_mode = load ? mode : pend_mode;
   assign apply    = has_pend && (wrap || (pend && pend_idle));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count     <= '0;
         tick      <= 1'b0;
         clk_out   <= 1'b0;
         cur_div   <= RST_DIV;
         cur_mode  <= DEFAULT_MODE;
         pend      <= 1'b0;
         pend_div  <= RST_DIV;
         pend_mode <= DEFAULT_MODE;
         pend_idle <= 1'b0;
      end else if (sync_clr) begin
         count     <= '0;
         tick      <= 1'b0;
         clk_out   <= 1'b0;
         pend      <= 1'b0;
         pend_idle <= 1'b0;
         if (has_pend) begin
            cur_div  <= new_div;
            cur_mode <= new_mode;
         end
      end else if (apply) begin
         // New period starts at count 0, which is always in the high half.
         count     <= '0;
         tick      <= wrap;
         clk_out   <= new_mode;
         cur_div   <= new_div;
         cur_mode  <= new_mode;
         pend      <= 1'b0;
         pend_idle <= 1'b0;
      end else begin
         if (en) begin
            count   <= next_count;
            tick    <= wrap;
            clk_out <= square_next;
         end else begin
            tick <= 1'b0;
         end
         if (load) begin
            pend_div  <= div;
            pend_mode <= mode;
            pend      <= 1'b1;
            pend_idle <= !en;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_freq_divider_prog.sv
`default_nettype none
// tb_freq_divider_prog : randomized scoreboard bench with a period-level reference model.
module tb_freq_divider_prog;

   localparam int WIDTH = 16;
   localparam int DDIV  = 16;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             en = 1'b0;
   logic             sync_clr = 1'b0;
   logic             load = 1'b0;
   logic [WIDTH-1:0] div = '0;
   logic             mode = 1'b0;
   logic             tick;
   logic             clk_out;
   logic [WIDTH-1:0] count;
   logic [WIDTH-1:0] cur_div;
   logic             pend;

   int checks = 0;
   int failures = 0;

   typedef struct {
      bit tick;
      bit clk;
      int count;
      int div;
      bit pend;
   } exp_t;

   exp_t exp_q[$];

   freq_divider_prog #(.WIDTH(WIDTH), .DEFAULT_DIV(DDIV), .DEFAULT_MODE(1'b0)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .sync_clr(sync_clr), .load(load),
      .div(div), .mode(mode), .tick(tick), .clk_out(clk_out), .count(count),
      .cur_div(cur_div), .pend(pend)
   );

   always #5 clk = ~clk;

   // Reference model: position within the current period plus the pending request.
   int m_pos = 0, m_div = DDIV, m_pdiv = 0;
   bit m_mode = 0, m_tick = 0, m_clk = 0, m_pend = 0, m_pmode = 0, m_idle_due = 0;

   function automatic int eff(int d);
      return (d == 0) ? 1 : d;
   endfunction

   function automatic bit in_high(int pos, int n);
      return pos < (n + 1) / 2;
   endfunction

   task automatic model_step();
      int  n;
      bit  ending;
      int  nd;
      bit  nm;
      if (!rst_n) begin
         m_pos = 0; m_tick = 0; m_clk = 0; m_div = DDIV; m_mode = 0;
         m_pend = 0; m_idle_due = 0;
         return;
      end
      n      = eff(m_div);
      ending = en && (m_pos == n - 1);
      nd     = load ? int'(div) : m_pdiv;
      nm     = load ? mode : m_pmode;
      if (sync_clr) begin
         m_pos = 0; m_tick = 0; m_clk = 0;
         if (load || m_pend) begin m_div = nd; m_mode = nm; end
         m_pend = 0; m_idle_due = 0;
      end else if ((load || m_pend) && (ending || (m_pend && m_idle_due))) begin
         m_div = nd; m_mode = nm;
         m_pos = 0; m_tick = ending; m_clk = m_mode && in_high(0, eff(m_div));
         m_pend = 0; m_idle_due = 0;
      end else begin
         if (en) begin
            m_pos  = ending ? 0 : m_pos + 1;
            m_tick = ending;
            m_clk  = m_mode && in_high(m_pos, n);
         end else begin
            m_tick = 0;
         end
         if (load) begin
            m_pdiv = int'(div); m_pmode = mode; m_pend = 1; m_idle_due = !en;
         end
      end
   endtask

   task automatic chk(string name, logic [31:0] act, logic [31:0] want);
      checks++;
      if (act !== want) begin
         failures++;
         $display("FAIL %s at t=%0t: got %0d expected %0d", name, $time, act, want);
      end
   endtask

   task automatic step();
      exp_t e;
      @(posedge clk);
      model_step();
      e.tick = m_tick; e.clk = m_clk; e.count = m_pos; e.div = m_div; e.pend = m_pend;
      exp_q.push_back(e);
      #1;
   endtask

   task automatic drive(bit r, bit e, bit c, bit l, int d, bit m);
      rst_n = r; en = e; sync_clr = c; load = l; div = WIDTH'(d); mode = m;
   endtask

   // Assert reset between edges and check that outputs react without a clock.
   task automatic async_reset();
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("async_tick", 32'(tick), 0);
      chk("async_clk_out", 32'(clk_out), 0);
      chk("async_count", 32'(count), 0);
      chk("async_cur_div", 32'(cur_div), DDIV);
      chk("async_pend", 32'(pend), 0);
      drive(0, 0, 0, 0, 0, 0);
      step();
   endtask

   always @(negedge clk) begin
      if (exp_q.size() != 0) begin
         exp_t e;
         e = exp_q.pop_front();
         chk("tick", 32'(tick), 32'(e.tick));
         chk("clk_out", 32'(clk_out), 32'(e.clk));
         chk("count", 32'(count), 32'(e.count));
         chk("cur_div", 32'(cur_div), 32'(e.div));
         chk("pend", 32'(pend), 32'(e.pend));
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int d;
      drive(0, 0, 0, 0, 0, 0);
      repeat (3) step();
      drive(1, 1, 0, 0, 0, 0);
      repeat (40) step();

      for (int i = 0; i < 4000; i++) begin
         case ($urandom_range(0, 9))
            0:       d = 0;
            1:       d = 1;
            2:       d = 2;
            default: d = int'($urandom_range(0, 20));
         endcase
         if ($urandom_range(0, 199) == 0) d = (1 << WIDTH) - 1;
         drive(1, $urandom_range(0, 99) < 85, $urandom_range(0, 99) < 2,
               $urandom_range(0, 99) < 6, d, 1'($urandom_range(0, 1)));
         step();
         if ($urandom_range(0, 299) == 0) async_reset();
      end
      async_reset();

      // Largest divisor: full square period, then a mid-period load applied at its wrap.
      drive(1, 1, 1, 1, (1 << WIDTH) - 1, 1);
      step();
      drive(1, 1, 0, 0, 0, 0);
      repeat (40000) step();
      drive(1, 1, 0, 1, 3, 0);
      step();
      drive(1, 1, 0, 0, 0, 0);
      repeat (25600) step();

      repeat (2) @(posedge clk);
      #1;
      chk("scoreboard_drained", 32'(exp_q.size()), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/freq_divider_prog.md
Name: freq_divider_prog

Overview:
Programmable clock-enable / clock divider. It is the parametrised successor of the fixed 16-count tick divider.
- Divisor is runtime-loadable with glitch-free update at period boundaries.
- Two output modes: single-cycle tick (pulse) and ~50% duty square wave.
- Adds count enable and synchronous clear.
- Drives PWM counters, LED dimmer refresh and slow timing strobes from the system clock.

Parameters:
- WIDTH, 16, width of divisor and counter.
- DEFAULT_DIV, 16, divisor active after reset. Must be < 2**WIDTH.
- DEFAULT_MODE, 0, mode active after reset (0 = pulse, 1 = square).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  count enable; counter and outputs hold while low.
- sync_clr  in  1  synchronous clear of the period.
- load  in  1  one-cycle strobe; captures div and mode as pending values.
- div  in  WIDTH  requested divisor N.
- mode  in  1  requested mode (0 pulse, 1 square).
- tick  out  1  one-cycle strobe per period (pulse mode).
- clk_out  out  1  square-wave output (square mode).
- count  out  WIDTH  current counter value.
- cur_div  out  WIDTH  divisor currently in effect.
- pend  out  1  a loaded value awaits application.

Behaviour:
- Reset is asynchronous, active-low: clk and rst_n exactly as named; rst_n low asynchronously forces the reset state, release is synchronous to clk.
- Reset values: count=0, tick=0, clk_out=0, cur_div=DEFAULT_DIV, active mode=DEFAULT_MODE, pend=0.
- All outputs are registered; no combinational path from inputs to outputs.
- Effective divisor Ne = max(cur_div, 1). A divisor of 0 is treated as 1.
- Counting: on each edge with en=1, count advances 0,1,...,Ne-1 and then wraps to 0.
- Wrap edge: the edge where count==Ne-1 and en=1.
- Pulse mode:
  - tick=1 for exactly the cycle following each wrap edge, otherwise 0.
  - Period is Ne cycles when en is held high.
  - Ne=1 gives tick=1 on every enabled cycle.
  - clk_out is held 0.
- Square mode:
  - clk_out is registered from the next count value: high while next count < ceil(Ne/2), low otherwise.
  - High time is ceil(Ne/2) cycles, low time floor(Ne/2). Ne=1 gives clk_out constant 1.
  - tick still pulses as in pulse mode.
- en=0: count, clk_out and cur_div hold; tick forced 0 on the next edge. Resuming en continues from the held count with no extra or lost cycles.
- Load rules:
  - load=1 registers div and mode into pending storage and sets pend=1.
  - Repeated loads before application overwrite the pending values; the last one wins.
- Application of pending values (clears pend):
  - At the next wrap edge, count goes to 0 and the new divisor and mode govern the following period.
  - If load coincides with a wrap edge, the values on the div/mode inputs take effect at that wrap.
  - If en=0 when load is seen, application happens on the next edge regardless of en. count resets to 0 at that edge.
- sync_clr=1 at an edge:
  - count=0, tick=0, clk_out=0.
  - Any pending value is applied immediately, including one being loaded on the same edge.
  - sync_clr overrides en.
- Priority: rst_n > sync_clr > pending apply > normal count.
- No mid-period truncation: a decreased divisor never causes count to exceed Ne-1, because application only occurs at wrap, clear or idle.
- Reset mid-operation discards pending and restores the defaults.
- Width: count and cur_div are WIDTH bits. Compare logic handles N = 2**WIDTH-1 without overflow.
- Half-period is computed as (Ne+1)>>1 in WIDTH+1 bits.

Test Plan:
1. Reset/defaults: hold rst_n low 3 cycles, release with en=1 → all outputs at reset values; tick first asserts 16 cycles after release, then every 16 cycles; count sequence 0..15.
2. Pulse mode N=10: load div=10 mode=0 → from the next wrap, tick period is 10 cycles with exactly one high cycle per period, for 5 periods.
3. Square mode N=5: load div=5 mode=1 → clk_out is 3 high, 2 low, repeating. Then N=4 gives 2/2, and N=1 gives constant 1.
4. Load mid-period:
   - With N=8 at count=3, load div=3 → pend=1, the current period completes all 8 cycles, then the period is 3 and pend drops at the wrap.
   - A load coincident with the wrap takes effect immediately.
5. Gating and clear:
   - Drop en for 7 cycles at count=5 → count holds 5 and tick stays 0; the next tick arrives exactly Ne-5 enabled cycles later.
   - Pulse sync_clr at count=6 → count=0 on the next cycle, and a pending div=12 is applied at once.
6. Edge values and async reset:
   - div=0 behaves as N=1.
   - div=2**WIDTH-1 wraps correctly.
   - Assert rst_n low mid-period between clock edges → outputs go to reset values immediately, without waiting for an edge.
